gpu_cmd_tx: RTL and testbench
=============================

Name: gpu_cmd_tx

Overview:
- CPU-side transmitter for the GPU command line.
- Accepts (opcode, parameter) requests over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each request onto the 16-bit cpuline in the exact frame rhythm the GPU command decoder samples.
- Tracks the GPU's idle two-phase rhythm internally, so commands always land in the GPU's opcode slot.

Parameters:
- FIFO_DEPTH, 4, number of buffered requests (power of 2, minimum 2).
- LW, 16, cpuline / opcode / parameter width.

Ports:
- clk  in  1  system clock, same clock as the GPU.
- clr  in  1  asynchronous active-low reset; must be released in the same cycle as the GPU reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request (not full).
- req_cmd  in  LW  opcode, legal values 16'hC0..16'hC6.
- req_param  in  LW  parameter word.
- cpuline  out  LW  registered word to the GPU.
- busy  out  1  FIFO non-empty or a command frame in progress.
- fifo_level  out  log2(FIFO_DEPTH)+1  entries held.
- err_opcode  out  1  sticky: an illegal opcode was offered.
- err_clr  in  1  synchronous clear of err_opcode.

Behaviour:
- Reset (clr low, asynchronous): cpuline=0, FIFO empty, fifo_level=0, busy=0, err_opcode=0, req_ready=1, frame counter at the start of a frame.
- Handshake: a transfer occurs on a rising edge when req_valid && req_ready. req_ready = !full; there is no bypass when full.
- Opcode check: if req_cmd is outside C0..C6 (including 0):
  - the transfer completes but the entry is dropped, with no FIFO write;
  - err_opcode is set on that edge;
  - err_clr and an illegal transfer on the same edge leave err_opcode = 1 (set wins).
- Cycle t means the cpuline value held between edge t and edge t+1, which the GPU samples at edge t+1. The first cycle after reset release is a frame start.
- Frames:
  - IDLE frame: 2 cycles, values [0, 0].
  - CMD frame: 3 cycles, values [cmd, param, 0]. The third word is ignored by the GPU (execute cycle) and is always driven as 0.
- Frame selection: at each frame start, if the FIFO is non-empty, pop the head and emit a CMD frame; otherwise emit an IDLE frame. A frame is never aborted or shortened.
- State machine:
  - F_A: first word of frame.
  - F_B: second word.
  - F_X: execute word, CMD frames only.
  - Transitions: F_A->F_B always; F_B->F_X if the current frame is CMD, otherwise F_B->F_A; F_X->F_A.
  - The pop decision is made in the cycle before F_A, so that the cpuline register loads the head opcode at the F_A edge.
- Latency: a request accepted at edge e into an empty FIFO appears on cpuline at the first frame start at or after edge e+1. Minimum latency is 1 cycle; worst case is 3 cycles when the FIFO is empty and a frame is in progress.
- Back-to-back: with the FIFO continuously non-empty, CMD frames are contiguous, giving one command per 3 cycles with no idle gap.
- Simultaneous push and pop: both take effect on the same edge; fifo_level is unchanged. When full, the pop frees space for the next cycle only.
- fifo_level saturates at FIFO_DEPTH; wrap-around of the FIFO pointers is modulo FIFO_DEPTH.
- Reset mid-frame: cpuline is forced to 0 immediately and FIFO contents are lost. After release, the frame rhythm restarts at F_A in lock-step with the GPU.

Decomposition:
- Shared package gpu_cmd_pkg:
  - opcode constants: OP_MODE=C0, OP_PUTC=C1, OP_BKSP=C2, OP_SETY=C3, OP_SETX=C4, OP_CLS=C5, OP_NEWLINE=C6;
  - IDLE_LEN=2, CMD_LEN=3;
  - frame state enum;
  - an opcode-legal function.
- Sub-module gpu_cmd_fifo: synchronous FIFO of 2*LW-bit entries with full, empty, level and async active-low clear, instantiated once.

Test Plan:
- Reset: hold clr low for 3 cycles -> cpuline=0, req_ready=1, busy=0, err_opcode=0; with no requests, cpuline stays 0 for 20 cycles.
- Single PUTC: offer {C1, 0x0041} one cycle after reset release -> cpuline is C1, 0041, 0 at the next frame start (cycle 2); busy falls after the execute word.
- Burst: offer C5/0, C3/0005, C1/0048 back-to-back -> cpuline is C5,0,0,C3,5,0,C1,48,0 contiguously, then [0,0] idle frames.
- Alignment: offer C4/000A in the second cycle of an idle frame -> C4 is held until the next frame start, never placed in an odd slot.
- Backpressure (FIFO_DEPTH=4): push 6 requests with req_valid held high -> req_ready low once full; all 6 frames emitted in order; fifo_level tracks 0..4.
- Errors and reset: offer opcode 0x0012 -> err_opcode=1, no frame emitted, FIFO untouched; pulse err_clr -> 0. Assert clr during the param word -> cpuline=0 at once and the frame is discarded.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the CPU-to-GPU command line: opcodes, frame lengths,
// frame-state encoding and the opcode legality check.
package gpu_cmd_pkg;

  localparam logic [15:0] OP_MODE    = 16'h00C0;
  localparam logic [15:0] OP_PUTC    = 16'h00C1;
  localparam logic [15:0] OP_BKSP    = 16'h00C2;
  localparam logic [15:0] OP_SETY    = 16'h00C3;
  localparam logic [15:0] OP_SETX    = 16'h00C4;
  localparam logic [15:0] OP_CLS     = 16'h00C5;
  localparam logic [15:0] OP_NEWLINE = 16'h00C6;

  localparam int IDLE_LEN = 2;
  localparam int CMD_LEN  = 3;

  typedef enum logic [1:0] {
    F_A = 2'd0,
    F_B = 2'd1,
    F_X = 2'd2
  } frame_state_e;

  function automatic logic op_legal(input logic [15:0] op);
    return (op >= OP_MODE) && (op <= OP_NEWLINE);
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous request FIFO with occupancy count; pointers wrap modulo DEPTH.
// Only the pointers and count are cleared; stored words are don't-care when empty.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_tx.sv
// CPU-side GPU command transmitter: buffers (opcode, param) requests and plays
// them onto cpuline as 3-word CMD frames, filling gaps with 2-word IDLE frames.
module gpu_cmd_tx
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = 16
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [LW-1:0]                 req_cmd,
  input  logic [LW-1:0]                 req_param,
  output logic [LW-1:0]                 cpuline,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_opcode,
  input  logic                          err_clr
);

  logic            full;
  logic            empty;
  logic            xfer;
  logic            legal;
  logic            push;
  logic            pop;
  logic            frame_end;
  logic            cmd_frame;
  logic [2*LW-1:0] head;
  logic [LW-1:0]   param_p0;
  logic [LW-1:0]   line_nxt;
  frame_state_e    state;
  frame_state_e    state_nxt;

  assign req_ready = !full;
  assign xfer      = req_valid && req_ready;
  assign legal     = op_legal(req_cmd);
  assign push      = xfer && legal;
  // The word after this one starts a new frame, so the head is claimed now.
  assign frame_end = (state == F_X) || ((state == F_B) && !cmd_frame);
  assign pop       = frame_end && !empty;
  assign busy      = !empty || cmd_frame;

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*LW)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({req_cmd, req_param}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nxt = F_A;
    line_nxt  = '0;
    unique case (state)
      F_A: begin
        state_nxt = F_B;
        if (cmd_frame) line_nxt = param_p0;
      end
      F_B: begin
        if (cmd_frame)  state_nxt = F_X;
        else if (pop)   line_nxt  = head[2*LW-1:LW];
      end
      F_X: begin
        if (pop) line_nxt = head[2*LW-1:LW];
      end
      default: begin
        state_nxt = F_A;
        line_nxt  = '0;
      end
    endcase
  end

  // Stage p0: frame state, output word and sticky error register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= F_A;
      cmd_frame  <= 1'b0;
      cpuline    <= '0;
      err_opcode <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpuline <= line_nxt;
      if (frame_end) cmd_frame <= !empty;
      if (xfer && !legal) err_opcode <= 1'b1;
      else if (err_clr)   err_opcode <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) param_p0 <= head[LW-1:0];
  end

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Directed bench for gpu_cmd_tx: a frame-level queue model checked every cycle,
// plus hand-computed cpuline sequences for each scenario.
module tb_gpu_cmd_tx;
  import gpu_cmd_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_cmd = '0;
  logic [15:0] req_param = '0;
  logic [15:0] cpuline;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        err_opcode;
  logic        err_clr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: pending requests, remaining words of the current frame
  // (front = word on the line now), whether that frame is a command frame.
  logic [31:0] mq[$];
  logic [15:0] frame[$];
  bit          m_cmd;
  bit          m_err;

  gpu_cmd_tx #(.FIFO_DEPTH(DEPTH), .LW(16)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_param  (req_param),
    .cpuline    (cpuline),
    .busy       (busy),
    .fifo_level (fifo_level),
    .err_opcode (err_opcode),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic m_reset();
    mq.delete();
    frame.delete();
    for (int i = 0; i < IDLE_LEN; i++) frame.push_back(16'h0);
    m_cmd = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic m_step();
    bit          rdy;
    bit          ok;
    logic [31:0] e;
    rdy = (mq.size() < DEPTH);
    ok  = (req_cmd >= 16'h00C0) && (req_cmd <= 16'h00C6);
    void'(frame.pop_front());
    if (frame.size() == 0) begin
      if (mq.size() != 0) begin
        e = mq.pop_front();
        frame.push_back(e[31:16]);
        frame.push_back(e[15:0]);
        frame.push_back(16'h0);
        m_cmd = 1'b1;
      end else begin
        for (int i = 0; i < IDLE_LEN; i++) frame.push_back(16'h0);
        m_cmd = 1'b0;
      end
    end
    if (req_valid && rdy && ok) mq.push_back({req_cmd, req_param});
    if (req_valid && rdy && !ok) m_err = 1'b1;
    else if (err_clr)            m_err = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge clr);
      if (!clr) m_reset();
      else      m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_cpuline", 32'(cpuline), 32'(frame[0]));
      chk("cyc_req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      chk("cyc_busy", 32'(busy), 32'((mq.size() != 0) || m_cmd));
      chk("cyc_fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("cyc_err_opcode", 32'(err_opcode), 32'(m_err));
    end
  end

  // Asserts reset away from the sampling edge, releases it on a negedge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    clr = 1'b0;
    req_valid = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpuline", 32'(cpuline), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err_opcode), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    clr = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [15:0] c, input logic [15:0] p);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_param = p;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(guard < 50), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  logic [15:0] got[16];
  logic [15:0] exp_burst[11];
  logic [15:0] exp_align[5];
  logic [15:0] ops[$];
  int          max_lvl;
  bit          saw_full;

  initial begin
    exp_burst = '{16'h00C5, 16'h0000, 16'h0000, 16'h00C3, 16'h0005, 16'h0000,
                  16'h00C1, 16'h0048, 16'h0000, 16'h0000, 16'h0000};
    exp_align = '{16'h0000, 16'h0000, 16'h00C4, 16'h000A, 16'h0000};

    clr = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_line", 32'(cpuline), 32'h0);
    end

    // Single PUTC offered in the first cycle after release
    do_reset();
    send(OP_PUTC, 16'h0041);
    chk("putc_c1", 32'(cpuline), 32'h0);
    @(negedge clk); chk("putc_c2", 32'(cpuline), 32'h00C1);
    @(negedge clk); chk("putc_c3", 32'(cpuline), 32'h0041);
    @(negedge clk); chk("putc_c4", 32'(cpuline), 32'h0000);
    chk("putc_busy_x", 32'(busy), 32'h1);
    @(negedge clk); chk("putc_busy_end", 32'(busy), 32'h0);

    // Burst of three back-to-back requests
    do_reset();
    fork
      begin
        send(OP_CLS, 16'h0000);
        send(OP_SETY, 16'h0005);
        send(OP_PUTC, 16'h0048);
      end
      begin
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          got[k] = cpuline;
        end
      end
    join
    for (int k = 0; k < 11; k++) chk($sformatf("burst_w%0d", k), 32'(got[k+2]), 32'(exp_burst[k]));

    // Request arriving in the second word of an idle frame
    do_reset();
    repeat (3) @(negedge clk);
    fork
      send(OP_SETX, 16'h000A);
      begin
        for (int k = 4; k <= 8; k++) begin
          @(negedge clk);
          got[k] = cpuline;
        end
      end
    join
    for (int k = 0; k < 5; k++) chk($sformatf("align_w%0d", k), 32'(got[k+4]), 32'(exp_align[k]));

    // Backpressure: six requests into a four-deep FIFO
    do_reset();
    ops.delete();
    max_lvl  = 0;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'h00C0 + i), 16'(i + 1));
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (cpuline >= 16'h00C0 && cpuline <= 16'h00C6) ops.push_back(cpuline);
          if (!req_ready) saw_full = 1'b1;
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
      end
    join
    chk("bp_max_level", 32'(max_lvl), 32'h4);
    chk("bp_saw_full", 32'(saw_full), 32'h1);
    chk("bp_frame_count", 32'(ops.size()), 32'h6);
    for (int i = 0; i < 6 && i < ops.size(); i++)
      chk($sformatf("bp_op%0d", i), 32'(ops[i]), 32'h00C0 + 32'(i));

    // Illegal opcodes and sticky error flag
    do_reset();
    send(16'h0012, 16'h1234);
    chk("err_set", 32'(err_opcode), 32'h1);
    chk("err_level", 32'(fifo_level), 32'h0);
    chk("err_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("err_no_frame", 32'(cpuline), 32'h0);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_opcode), 32'h0);
    err_clr = 1'b1;
    send(16'h00C7, 16'h0000);
    err_clr = 1'b0;
    chk("err_set_wins", 32'(err_opcode), 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    send(16'h0000, 16'h0000);
    chk("err_zero_op", 32'(err_opcode), 32'h1);

    // Reset during the parameter word discards the frame and queued work
    do_reset();
    send(OP_NEWLINE, 16'h0077);
    send(OP_BKSP, 16'h0000);
    chk("mid_opcode", 32'(cpuline), 32'h00C6);
    @(posedge clk);
    #2;
    chk("mid_param", 32'(cpuline), 32'h0077);
    clr = 1'b0;
    #1;
    chk("mid_forced0", 32'(cpuline), 32'h0);
    chk("mid_level0", 32'(fifo_level), 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_after", 32'(cpuline), 32'h0);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
